// File: rtl/steamer16_bus_responder.sv
// Wait-stated 16-bit memory responder with byte lanes.
// Define ZERO_WAIT_FETCH_EN to service opcode fetches without waits.
module steamer16_bus_responder #(
  parameter logic [15:1] BASE_ADR    = 15'h7F00,
  parameter int          ADR_BITS    = 8,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic [15:1] adr_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic [1:0]  stb_i,
  input  logic        vda_i,
  input  logic        vpa_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  output logic        ack_o
);

  localparam logic [3:0] WS_M1 =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ack_q;
  logic [15:0]          dat_q;
  logic [15:0]          mem_q [2**ADR_BITS];
  logic [ADR_BITS-1:0]  idx;
  logic                 hit, req, fast, enter_ack;

  assign idx = adr_i[ADR_BITS:1];
  assign hit = adr_i[15:ADR_BITS+1] ==
               BASE_ADR[15:ADR_BITS+1];
  assign req = cyc_i & (|stb_i) & hit;

`ifdef ZERO_WAIT_FETCH_EN
  assign fast = vpa_i & ~vda_i;
`else
  logic unused_qual;
  assign unused_qual = vpa_i ^ vda_i;
  assign fast = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, ACK: begin
        if (!req) begin
          state_d = IDLE;
        end else if (WAIT_STATES == 0 || fast) begin
          state_d = ACK;
        end else begin
          state_d = WAIT;
          cnt_d   = WS_M1;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ACK->ACK is a fresh transfer, so every edge into ACK counts
  assign enter_ack = (state_d == ACK);

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      dat_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_ack;
      if (enter_ack && !we_i) begin
        dat_q <= mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!res_i && enter_ack && we_i) begin
      if (stb_i[1]) mem_q[idx][15:8] <= dat_i[15:8];
      if (stb_i[0]) mem_q[idx][7:0]  <= dat_i[7:0];
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;

endmodule

// File: tb/tb_steamer16_bus_responder.sv
// Directed bench: four responders with 1, 3, 2 and 0 waits
// sharing one bus; each test checks the instance it targets.
module tb_steamer16_bus_responder;

  localparam int A = 0;
  localparam int B = 1;
  localparam int C = 2;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [15:1] adr = '0;
  logic        we  = 1'b0;
  logic        cyc = 1'b0;
  logic [1:0]  stb = 2'b00;
  logic        vda = 1'b0;
  logic        vpa = 1'b0;
  logic [15:0] dat_w = '0;

  logic [15:0] dat_a, dat_b, dat_c, dat_d;
  logic        ack_a, ack_b, ack_c, ack_d;

  int tests = 0;
  int fails = 0;
  int lat;
  logic [15:0] rd;

  always #5 clk = ~clk;

  steamer16_bus_responder #(.WAIT_STATES(1)) u_a (
    .clk_i(clk), .res_i(res), .adr_i(adr), .we_i(we),
    .cyc_i(cyc), .stb_i(stb), .vda_i(vda), .vpa_i(vpa),
    .dat_i(dat_w), .dat_o(dat_a), .ack_o(ack_a));

  steamer16_bus_responder #(.WAIT_STATES(3)) u_b (
    .clk_i(clk), .res_i(res), .adr_i(adr), .we_i(we),
    .cyc_i(cyc), .stb_i(stb), .vda_i(vda), .vpa_i(vpa),
    .dat_i(dat_w), .dat_o(dat_b), .ack_o(ack_b));

  steamer16_bus_responder #(.WAIT_STATES(2)) u_c (
    .clk_i(clk), .res_i(res), .adr_i(adr), .we_i(we),
    .cyc_i(cyc), .stb_i(stb), .vda_i(vda), .vpa_i(vpa),
    .dat_i(dat_w), .dat_o(dat_c), .ack_o(ack_c));

  steamer16_bus_responder #(.WAIT_STATES(0)) u_d (
    .clk_i(clk), .res_i(res), .adr_i(adr), .we_i(we),
    .cyc_i(cyc), .stb_i(stb), .vda_i(vda), .vpa_i(vpa),
    .dat_i(dat_w), .dat_o(dat_d), .ack_o(ack_d));

  function automatic logic ack_of(input int s);
    case (s)
      A:       return ack_a;
      B:       return ack_b;
      C:       return ack_c;
      default: return ack_d;
    endcase
  endfunction

  function automatic logic [15:0] dat_of(input int s);
    case (s)
      A:       return dat_a;
      B:       return dat_b;
      C:       return dat_c;
      default: return dat_d;
    endcase
  endfunction

  task automatic bus_idle();
    cyc = 1'b0;
    stb = 2'b00;
    we  = 1'b0;
    vpa = 1'b0;
    vda = 1'b0;
  endtask

  task automatic xfer(
    input  int          s,
    input  logic        w,
    input  logic [15:1] a,
    input  logic [1:0]  st,
    input  logic [15:0] d,
    input  logic        pa,
    input  logic        da,
    output int          l,
    output logic [15:0] r
  );
    bus_idle();
    @(posedge clk); #1;
    adr = a; we = w; stb = st; dat_w = d;
    vpa = pa; vda = da; cyc = 1'b1;
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack_of(s)) begin
        l = i;
        break;
      end
    end
    r = dat_of(s);
    bus_idle();
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ack_a, ack_b, ack_c, ack_d} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_ack got %b want 0000",
               {ack_a, ack_b, ack_c, ack_d});
    end
    tests++;
    if (dat_a !== 16'h0000 || dat_b !== 16'h0000) begin
      fails++;
      $display("FAIL rst_dat_ab got %h %h want 0",
               dat_a, dat_b);
    end
    tests++;
    if (dat_c !== 16'h0000 || dat_d !== 16'h0000) begin
      fails++;
      $display("FAIL rst_dat_cd got %h %h want 0",
               dat_c, dat_d);
    end
    res = 1'b0;
  endtask

  task automatic test_write_read();
    xfer(A, 1'b1, 15'h7F10, 2'b11, 16'hBEEF, 0, 0, lat, rd);
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL wr_lat got %0d want 2", lat);
    end
    xfer(A, 1'b0, 15'h7F10, 2'b11, 16'h0000, 0, 0, lat, rd);
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL rd_lat got %0d want 2", lat);
    end
    tests++;
    if (rd !== 16'hBEEF) begin
      fails++;
      $display("FAIL rd_beef got %h want beef", rd);
    end
  endtask

  task automatic test_lanes();
    xfer(A, 1'b1, 15'h7F20, 2'b11, 16'h1234, 0, 0, lat, rd);
    tests++;
    if (rd !== 16'hBEEF) begin
      fails++;
      $display("FAIL wr_keeps_dat got %h want beef", rd);
    end
    xfer(A, 1'b1, 15'h7F20, 2'b10, 16'hAB00, 0, 0, lat, rd);
    xfer(A, 1'b0, 15'h7F20, 2'b11, 16'h0000, 0, 0, lat, rd);
    tests++;
    if (rd !== 16'hAB34) begin
      fails++;
      $display("FAIL lane_hi got %h want ab34", rd);
    end
    xfer(A, 1'b1, 15'h7F20, 2'b01, 16'hFFCD, 0, 0, lat, rd);
    xfer(A, 1'b0, 15'h7F20, 2'b01, 16'h0000, 0, 0, lat, rd);
    tests++;
    if (rd !== 16'hABCD) begin
      fails++;
      $display("FAIL lane_lo got %h want abcd", rd);
    end
  endtask

  task automatic test_miss();
    int hits;
    bus_idle();
    @(posedge clk); #1;
    adr = 15'h0010; stb = 2'b11; cyc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++;
      if (ack_a !== 1'b0) begin
        fails++;
        $display("FAIL miss_low cyc %0d got %b want 0",
                 i, ack_a);
      end
    end
    adr = 15'h7EFF;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack_a !== 1'b0 || ack_d !== 1'b0) hits++;
    end
    tests++;
    if (hits !== 0) begin
      fails++;
      $display("FAIL miss_7eff got %0d acks want 0", hits);
    end
    adr = 15'h7F10; stb = 2'b00;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack_a !== 1'b0 || ack_d !== 1'b0) hits++;
    end
    tests++;
    if (hits !== 0) begin
      fails++;
      $display("FAIL stb_none got %0d acks want 0", hits);
    end
    xfer(A, 1'b1, 15'h7FFF, 2'b11, 16'h0A5A, 0, 0, lat, rd);
    xfer(A, 1'b0, 15'h7FFF, 2'b11, 16'h0000, 0, 0, lat, rd);
    tests++;
    if (lat !== 2 || rd !== 16'h0A5A) begin
      fails++;
      $display("FAIL top_word got %0d/%h want 2/0a5a",
               lat, rd);
    end
  endtask

  task automatic test_latency();
    xfer(D, 1'b1, 15'h7F50, 2'b11, 16'hC3C3, 0, 0, lat, rd);
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL ws0_wr_lat got %0d want 1", lat);
    end
    xfer(D, 1'b0, 15'h7F50, 2'b11, 16'h0000, 0, 0, lat, rd);
    tests++;
    if (lat !== 1 || rd !== 16'hC3C3) begin
      fails++;
      $display("FAIL ws0_rd got %0d/%h want 1/c3c3",
               lat, rd);
    end
    xfer(B, 1'b1, 15'h7F50, 2'b11, 16'h3C3C, 0, 0, lat, rd);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL ws3_wr_lat got %0d want 4", lat);
    end
    xfer(B, 1'b0, 15'h7F50, 2'b11, 16'h0000, 0, 0, lat, rd);
    tests++;
    if (lat !== 4 || rd !== 16'h3C3C) begin
      fails++;
      $display("FAIL ws3_rd got %0d/%h want 4/3c3c",
               lat, rd);
    end
  endtask

  task automatic test_abort();
    int hits;
    xfer(B, 1'b1, 15'h7F30, 2'b11, 16'h5555, 0, 0, lat, rd);
    bus_idle();
    @(posedge clk); #1;
    adr = 15'h7F30; we = 1'b1; stb = 2'b11;
    dat_w = 16'hAAAA; cyc = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ack_b !== 1'b0) hits++;
      if (i == 1) cyc = 1'b0;
    end
    tests++;
    if (hits !== 0) begin
      fails++;
      $display("FAIL abort_ack got %0d acks want 0", hits);
    end
    xfer(B, 1'b0, 15'h7F30, 2'b11, 16'h0000, 0, 0, lat, rd);
    tests++;
    if (lat !== 4 || rd !== 16'h5555) begin
      fails++;
      $display("FAIL abort_data got %0d/%h want 4/5555",
               lat, rd);
    end
  endtask

  task automatic test_reset_mid();
    xfer(A, 1'b0, 15'h7F10, 2'b11, 16'h0000, 0, 0, lat, rd);
    tests++;
    if (rd !== 16'hBEEF) begin
      fails++;
      $display("FAIL pre_rst got %h want beef", rd);
    end
    bus_idle();
    @(posedge clk); #1;
    adr = 15'h7F10; we = 1'b1; stb = 2'b11;
    dat_w = 16'h0000; cyc = 1'b1;
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (ack_a !== 1'b0 || dat_a !== 16'h0000) begin
      fails++;
      $display("FAIL mid_rst got %b/%h want 0/0000",
               ack_a, dat_a);
    end
    res = 1'b0;
    bus_idle();
    xfer(A, 1'b0, 15'h7F10, 2'b11, 16'h0000, 0, 0, lat, rd);
    tests++;
    if (lat !== 2 || rd !== 16'hBEEF) begin
      fails++;
      $display("FAIL post_rst got %0d/%h want 2/beef",
               lat, rd);
    end
  endtask

  task automatic test_back_to_back();
    int na, nb, nc, nd;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    adr = 15'h7F10; we = 1'b0; stb = 2'b11;
    vda = 1'b1; cyc = 1'b1;
    na = 0; nb = 0; nc = 0; nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      na += int'(ack_a);
      nb += int'(ack_b);
      nc += int'(ack_c);
      nd += int'(ack_d);
    end
    bus_idle();
    tests++;
    if (na !== 4 || nd !== 8) begin
      fails++;
      $display("FAIL b2b_ad got %0d/%0d want 4/8", na, nd);
    end
    tests++;
    if (nb !== 2 || nc !== 2) begin
      fails++;
      $display("FAIL b2b_bc got %0d/%0d want 2/2", nb, nc);
    end
  endtask

  task automatic test_fetch();
    int want;
`ifdef ZERO_WAIT_FETCH_EN
    want = 1;
`else
    want = 3;
`endif
    xfer(C, 1'b1, 15'h7F40, 2'b11, 16'h0F0F, 0, 1, lat, rd);
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL data_wr_lat got %0d want 3", lat);
    end
    xfer(C, 1'b0, 15'h7F40, 2'b11, 16'h0000, 1, 0, lat, rd);
    tests++;
    if (lat !== want || rd !== 16'h0F0F) begin
      fails++;
      $display("FAIL fetch got %0d/%h want %0d/0f0f",
               lat, rd, want);
    end
    xfer(C, 1'b0, 15'h7F40, 2'b11, 16'h0000, 1, 1, lat, rd);
    tests++;
    if (lat !== 3 || rd !== 16'h0F0F) begin
      fails++;
      $display("FAIL data_rd got %0d/%h want 3/0f0f",
               lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_lanes();
    test_miss();
    test_latency();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
